hazard_stall_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline; drives stall/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/hazard_stall_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush controller for load-use, redirect, memory wait and sync drain
// Outputs are combinational from state and inputs; state, drain count and stall counter are registered.
module hazard_stall_ctrl #(
  parameter int SYNC_DRAIN_CYCLES = 3,
  parameter int CNT_W             = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_id,
  input  logic [4:0]       id_rt_id,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_sync,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_reg_dst_id,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = (SYNC_DRAIN_CYCLES < 2) ? 1 : $clog2(SYNC_DRAIN_CYCLES);
  localparam logic [DW-1:0] CNT_INIT = DW'(SYNC_DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    SYNC_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  logic   [DW-1:0] cnt_q, cnt_d;
  state_t          eff_state;
  logic            load_use;
  logic            freeze;

  assign load_use = ex_mem_to_reg && (ex_reg_dst_id != 5'd0) &&
                    ((id_uses_rs && (id_rs_id == ex_reg_dst_id)) ||
                     (id_uses_rt && (id_rt_id == ex_reg_dst_id)));

  assign freeze = !mem_ready && (mem_req || (state_q == MEM_WAIT));

  // Leaving MEM_WAIT resumes the saved state within the same cycle.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    state_d       = state_q;
    ret_d         = ret_q;
    cnt_d         = cnt_q;
    if (rst) begin
      state_d = RUN;
    end else if (freeze) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_wb_bubble = 1'b1;
      state_d       = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
    end else begin
      state_d = eff_state;
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = RUN;
        cnt_d       = '0;
      end else if (eff_state == SYNC_DRAIN) begin
        if (cnt_q != '0) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - DW'(1);
        end else begin
          state_d = RUN;
        end
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_is_sync) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        cnt_d       = CNT_INIT;
        state_d     = SYNC_DRAIN;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= RUN;
      ret_q        <= RUN;
      cnt_q        <= '0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl with directed and random stimulus
module tb_hazard_stall_ctrl;

  localparam int N     = 3;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs_id = '0, id_rt_id = '0, ex_reg_dst_id = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_is_sync = 0, ex_mem_to_reg = 0;
  logic ex_redirect = 0, mem_req = 0, mem_ready = 1;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush;
  logic [CNT_W-1:0] stall_cycles;

  hazard_stall_ctrl #(.SYNC_DRAIN_CYCLES(N), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .id_rs_id(id_rs_id), .id_rt_id(id_rt_id), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_sync(id_is_sync), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst_id(ex_reg_dst_id),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .stall_cycles(stall_cycles)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [6:0] ctrl;
    int         cnt;
    bit         chk_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pipeline situation tracked as plain flags and a count of drain stalls left
  bit m_known = 0;
  bit m_waiting = 0;
  bit m_draining = 0;
  bit m_ret_draining = 0;
  int m_left = 0;
  int m_count = 0;

  localparam logic [6:0] FREEZE_V = 7'b1111100;
  localparam logic [6:0] HOLD_V   = 7'b1100001;
  localparam logic [6:0] FLUSH_V  = 7'b0000011;

  task automatic drive(input bit r, input int rs, input int rt, input bit urs, input bit urt,
                       input bit sy, input bit ld, input int dst, input bit rd,
                       input bit mq, input bit mr);
    exp_t e;
    bit   lu;
    @(posedge sys_clk);
    #1;
    rst = r; id_rs_id = 5'(rs); id_rt_id = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_is_sync = sy; ex_mem_to_reg = ld; ex_reg_dst_id = 5'(dst); ex_redirect = rd;
    mem_req = mq; mem_ready = mr;
    e.ctrl = '0;
    e.cnt = m_count;
    e.chk_cnt = m_known;
    lu = ld && dst != 0 && ((urs && rs == dst) || (urt && rt == dst));
    if (r) begin
      m_waiting = 0; m_draining = 0; m_left = 0; m_count = 0; m_known = 1;
    end else if (!mr && (mq || m_waiting)) begin
      e.ctrl = FREEZE_V;
      if (!m_waiting) m_ret_draining = m_draining;
      m_waiting = 1;
    end else begin
      if (m_waiting) m_draining = m_ret_draining;
      m_waiting = 0;
      if (rd) begin
        e.ctrl = FLUSH_V;
        m_draining = 0;
      end else if (m_draining) begin
        if (m_left > 0) begin
          e.ctrl = HOLD_V;
          m_left--;
        end else begin
          m_draining = 0;
        end
      end else if (lu) begin
        e.ctrl = HOLD_V;
      end else if (sy) begin
        e.ctrl = HOLD_V;
        m_left = N - 1;
        m_draining = 1;
      end
    end
    if (!r && e.ctrl[6] && m_count < SAT) m_count++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    logic [6:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble, if_id_flush, id_ex_flush};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, act, e.ctrl);
      end
      if (e.chk_cnt) begin
        checks++;
        if (int'(stall_cycles) != e.cnt) begin
          errors++;
          $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use on rs, then clear
    drive(0, 5, 0, 1, 0, 0, 1, 5, 0, 0, 1);
    idle(2);
    // r0 never stalls; redirect outranks load-use
    drive(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1);
    drive(0, 7, 3, 0, 1, 0, 1, 3, 1, 0, 1);
    idle(1);
    // four-cycle memory wait
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // sync drain
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N + 1; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    idle(1);
    // sync drain interrupted by a two-cycle memory wait
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    // reset in the middle of a drain
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    idle(2);
    // saturate the counter with a long freeze
    for (int i = 0; i < SAT + 20; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    idle(2);
    @(posedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
